// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 multiply / restoring divide unit that owns
//               the HI/LO register pair. MTHI/MTLO write HI/LO in zero cycles.
//               Define MULDIV_MADD_EN to add MADD/MADDU (ops 110/111).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  C_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] C_OP_MULT  = 3'b000;
    localparam logic [2:0] C_OP_MULTU = 3'b001;
    localparam logic [2:0] C_OP_DIV   = 3'b010;
    localparam logic [2:0] C_OP_DIVU  = 3'b011;
    localparam logic [2:0] C_OP_MTHI  = 3'b100;
    localparam logic [2:0] C_OP_MTLO  = 3'b101;
    localparam logic [2:0] C_OP_MADD  = 3'b110;
    localparam logic [2:0] C_OP_MADDU = 3'b111;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_dbz;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic               r_dbz_flag;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_madd;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_idle;
    logic               w_accept;
    logic               w_mt;
    logic               w_b_zero;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_fix_res;

`ifdef MULDIV_MADD_EN
    logic               r_madd;
    assign w_is_madd = (op == C_OP_MADD) || (op == C_OP_MADDU);
`else
    assign w_is_madd = 1'b0;
`endif

    // Operation decode and operand magnitudes
    assign w_is_mul = (op == C_OP_MULT) || (op == C_OP_MULTU) || w_is_madd;
    assign w_is_div = (op == C_OP_DIV) || (op == C_OP_DIVU);
    assign w_signed = (op == C_OP_MULT) || (op == C_OP_DIV) || (op == C_OP_MADD);
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = start && w_idle && (w_is_mul || w_is_div);
    assign w_mt     = start && w_idle && ((op == C_OP_MTHI) || (op == C_OP_MTLO));
    assign w_b_zero = (b == {WIDTH{1'b0}});
    assign w_a_neg  = w_signed && a[WIDTH-1];
    assign w_b_neg  = w_signed && b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // One iteration: multiply shifts right through the product, divide shifts
    // the remainder/quotient pair left and keeps the trial subtraction if it
    // did not go negative.
    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                       + {1'b0, (r_prod[0] ? r_opnd : {WIDTH{1'b0}})};
    assign w_div_trial = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]} - {1'b0, r_opnd};

    always_comb begin
        w_step = {r_prod[2*WIDTH-2:0], 1'b0};
        if (!r_is_div) begin
            w_step = {w_mul_sum, r_prod[WIDTH-1:1]};
        end else if (!w_div_trial[WIDTH]) begin
            w_step = {w_div_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
        end
    end

    assign w_mul_res = r_neg_q ? -r_prod : r_prod;
    assign w_quo     = r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
    assign w_rem     = r_neg_r ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

    always_comb begin
        if (r_dbz) begin
            w_fix_res = r_prod;
        end else if (r_is_div) begin
            w_fix_res = {w_rem, w_quo};
        end else begin
            w_fix_res = w_mul_res;
`ifdef MULDIV_MADD_EN
            if (r_madd) begin
                w_fix_res = {r_hi, r_lo} + w_mul_res;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_is_div && w_b_zero) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == C_CNT_ONE) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        done        = r_done;
        div_by_zero = r_dbz_flag;
        hi          = r_hi;
        lo          = r_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_prod     <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_dbz      <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_done     <= 1'b0;
            r_dbz_flag <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
`ifdef MULDIV_MADD_EN
            r_madd     <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_dbz_flag <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= C_CNT_INIT;
                        r_is_div <= w_is_div;
                        r_dbz    <= w_is_div && w_b_zero;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                        if (w_is_div && w_b_zero) begin
                            r_prod <= {a, {WIDTH{1'b1}}};
                        end else begin
                            r_prod <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        end
`ifdef MULDIV_MADD_EN
                        r_madd   <= w_is_madd;
`endif
                    end else if (w_mt) begin
                        if (op == C_OP_MTHI) begin
                            r_hi <= a;
                        end else begin
                            r_lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    r_prod <= w_step;
                    r_cnt  <= r_cnt - C_CNT_ONE;
                end
                S_FIX: begin
                    r_hi       <= w_fix_res[2*WIDTH-1:WIDTH];
                    r_lo       <= w_fix_res[WIDTH-1:0];
                    r_done     <= 1'b1;
                    r_dbz_flag <= r_dbz;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (WIDTH=32): directed
//               vector table, handshake corner sequences and random ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int          W     = 32;
    localparam logic [31:0] C_MIN = 32'h8000_0000;
    localparam logic [31:0] C_ONES = 32'hFFFF_FFFF;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Arithmetic reference: plain 64-bit products and SV division semantics
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] x,
                                      input logic [31:0] y, output logic [31:0] h,
                                      output logic [31:0] l, output logic z);
        longint      sx, sy, p;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            3'd0: begin p = sx * sy; u = p; h = u[63:32]; l = u[31:0]; end
            3'd1: begin u = {32'b0, x} * {32'b0, y}; h = u[63:32]; l = u[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    h = x; l = C_ONES; z = 1'b1;
                end else if (o == 3'd2 && x == C_MIN && y == C_ONES) begin
                    h = 32'd0; l = C_MIN;
                end else if (o == 3'd2) begin
                    l = 32'(sx / sy); h = 32'(sx % sy);
                end else begin
                    l = x / y; h = x % y;
                end
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    // lat counts rising edges after the accepting edge.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] x);
        start = 1'b1; op = o; a = x; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t        vecs[7];
    int          lat;
    int          cnt_done;
    int          cnt_busy;
    logic [31:0] eh, el, save_hi, save_lo;
    logic        ez;
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"mult_neg3x7",   3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
        vecs[1] = '{"multu_max",     3'd1, C_ONES,        C_ONES,       32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[2] = '{"div_neg7_2",    3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[3] = '{"divu_100_7",    3'd3, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 33};
        vecs[4] = '{"div_overflow",  3'd2, C_MIN,         C_ONES,       32'd0,         C_MIN,         1'b0, 33};
        vecs[5] = '{"div_by_zero",   3'd2, 32'd5,         32'd0,        32'd5,         C_ONES,        1'b1, 1};
        vecs[6] = '{"divu_after_dz", 3'd3, 32'd9,         32'd3,        32'd0,         32'd3,         1'b0, 33};

        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_dbz",  div_by_zero, 1'b0);
        chk("reset_hi",   hi, 32'd0);
        chk("reset_lo",   lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, "_hi"},  hi,  vecs[i].hi);
            chk({vecs[i].name, "_lo"},  lo,  vecs[i].lo);
            chk({vecs[i].name, "_dbz"}, div_by_zero, vecs[i].dbz);
            @(negedge clk);
            chk({vecs[i].name, "_done_pulse"}, {done, div_by_zero, busy}, 3'b000);
        end

        // Second start while busy must be dropped
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 4) begin
                start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("ignored_start_lat", lat, 33);
        chk("ignored_start_lo", lo, 32'd30);
        chk("ignored_start_hi", hi, 32'd0);
        cnt_done = 0;
        cnt_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (busy) cnt_busy++;
        end
        chk("ignored_start_no_extra_done", cnt_done, 0);
        chk("ignored_start_no_extra_busy", cnt_busy, 0);

        // Back-to-back issue in the done cycle
        do_op(3'd3, 32'd100, 32'd7, lat);
        chk("b2b_first_lo", lo, 32'd14);
        do_op(3'd1, 32'd3, 32'd5, lat);
        chk("b2b_second_lat", lat, 33);
        chk("b2b_second_lo", lo, 32'd15);
        chk("b2b_second_hi", hi, 32'd0);
        @(negedge clk);

        // MTHI / MTLO: zero latency, no handshake activity
        save_lo = lo;
        mt(3'd4, 32'h1234);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo_kept", lo, save_lo);
        chk("mthi_busy_done", {busy, done}, 2'b00);
        mt(3'd5, 32'hABCD);
        chk("mtlo_lo", lo, 32'hABCD);
        chk("mtlo_hi_kept", hi, 32'h1234);

        // Reset in the middle of a divide
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        chk("abort_no_done", cnt_done, 0);

`ifdef MULDIV_MADD_EN
        mt(3'd4, 32'd0);
        mt(3'd5, 32'd10);
        do_op(3'd6, 32'd3, 32'd4, lat);
        chk("madd_lat", lat, 33);
        chk("madd_lo", lo, 32'd22);
        chk("madd_hi", hi, 32'd0);
        @(negedge clk);
        mt(3'd4, 32'd0);
        mt(3'd5, 32'd0);
        do_op(3'd6, C_ONES, 32'd1, lat);
        chk("madd_neg_hi", hi, C_ONES);
        chk("madd_neg_lo", lo, C_ONES);
        @(negedge clk);
`else
        mt(3'd4, 32'h55);
        mt(3'd5, 32'hAA);
        start = 1'b1; op = 3'd6; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("op110_no_busy", busy, 1'b0);
        cnt_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) cnt_done++;
        end
        chk("op110_no_activity", cnt_done, 0);
        chk("op110_hi_kept", hi, 32'h55);
        chk("op110_lo_kept", lo, 32'hAA);
`endif

        // Randomised operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin rx = C_MIN; ry = C_ONES; end
                2: ry = 32'($urandom_range(1, 5));
                3: ry = -32'($urandom_range(1, 5));
                default: ;
            endcase
            ref_model(ro, rx, ry, eh, el, ez);
            do_op(ro, rx, ry, lat);
            chk("rand_lat", lat, ez ? 1 : 33);
            chk("rand_hi", hi, eh);
            chk("rand_lo", lo, el);
            chk("rand_dbz", div_by_zero, ez);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the Mini-MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over a start/busy/done handshake. It sits beside the ALU: operands come from register-file read ports rs/rt, and HI/LO feed the write-back mux for MFHI/MFLO. The core stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width; legal range ≥ 4.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  operation request; sampled only while `busy`=0.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 see Configuration; otherwise no-op.
- `a`  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an iterative op.
- `div_by_zero`  out  1  valid with `done`; set when DIV/DIVU had `b`=0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - `start` with a MUL/DIV op latches operand magnitudes. For signed ops, take the absolute value and record the result signs. Load counter = WIDTH, go to RUN.
  - MTHI/MTLO write `a` to hi/lo at the same edge. State stays IDLE, no `busy`, no `done`.
- RUN, multiply: radix-2 shift-add on magnitudes, one bit per cycle, 2·WIDTH-bit product.
- RUN, divide: restoring division, one quotient bit per cycle.
- Counter decrements each RUN cycle; at 0 go to FIX.
- FIX:
  - Apply sign correction. Signed MULT product is negated if operand signs differ. Signed DIV quotient is negated if signs differ; remainder takes the dividend's sign.
  - Write hi (product upper / remainder) and lo (product lower / quotient).
  - Pulse `done`, return to IDLE.
- Divide by zero (`b`=0): skip RUN. The next edge writes hi=`a`, lo=all-ones, and pulses `done` with `div_by_zero`=1.
- Signed overflow (DIV MIN / −1): lo=MIN (0x80000000 at WIDTH=32), hi=0; no flag.
- `start` while `busy`=1 is ignored (no queueing, no error).
- hi/lo hold previous values for the whole operation and change only at FIX or an MTHI/MTLO edge.
- Internal counter width: $clog2(WIDTH+1).

## Timing
- Reset (asynchronous, immediate): state IDLE, `busy`=0, `done`=0, `div_by_zero`=0, hi=0, lo=0, operation discarded.
- Start accepted at edge E0:
  - `busy`=1 after E0.
  - Iterations occur at E1..E_WIDTH.
  - FIX at E_{WIDTH+1}: hi/lo valid, `done`=1, `busy`=0 after that edge.
  - Latency WIDTH+1 cycles (33 at WIDTH=32).
- Divide by zero: `done` after E1; `busy` high for one cycle.
- `done`/`div_by_zero` are high exactly one cycle.
- A new `start` may be accepted in the same cycle `done` is high (back-to-back issue).
- MTHI/MTLO: hi/lo update at E0, zero latency, usable by MFHI/MFLO next cycle.
- Reset during RUN/FIX: the operation is aborted and nothing is written.

## Configuration
- `MULDIV_MADD_EN` defined:
  - op 110 = MADD (signed) and 111 = MADDU: {hi,lo} ← {hi,lo} + a·b, mod 2^(2·WIDTH).
  - The addition happens in FIX, so latency is identical to MULT.
  - Flags and handshake are as for MULT.
- Not defined: ops 110/111 are ignored, like any undefined op; no accumulator adder is synthesised.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → `done` 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, `div_by_zero`=0.
- DIV a=5, b=0 → `done` and `div_by_zero` one cycle after start; hi=5, lo=0xFFFFFFFF; next op clears the flag.
- MULT running, second `start` (DIVU) at cycle 5 → ignored; result is the MULT only. Back-to-back start in the `done` cycle → accepted, second `done` 33 cycles later.
- MTHI a=0x1234 → hi=0x1234 next edge, `busy`/`done` stay 0. Reset asserted at cycle 10 of a DIV → hi=lo=0, `busy`=0 immediately, no `done`.
- With `MULDIV_MADD_EN`: MTHI 0, MTLO 10, MADD a=3, b=4 → lo=22, hi=0. MADD a=−1, b=1 from {0,0} → hi=lo=0xFFFFFFFF. Without the macro, op 110 → no `busy`, hi/lo unchanged.
